// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous value commit.
// Latency: Anodes/Cathodes are registered, one cycle behind slot_cnt/digit_idx/disp_reg.
// Backpressure: load_ready drops after a capture and returns one cycle after the
// value is committed at the next frame boundary. Offers made while it is low are ignored.
//
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   load_valid/ready valid/ready handshake for load_value (packed nibbles, digit 0 = [3:0])
//   blank            forces all anodes off, scanning continues
//   frame_tick       one-cycle pulse on the cycle the digit index wraps to 0
//   Anodes           active-low one-hot digit enables
//   Cathodes         active-low segments {g,f,e,d,c,b,a}
// Build option: define SEG7_LZ_BLANK_EN for leading-zero blanking.

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    blank,
  output logic                    frame_tick,
  output logic [NUM_DIGITS-1:0]   Anodes,
  output logic [6:0]              Cathodes
);

  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] DEAD_LIM   = SW'(DEAD_CYCLES);

  logic [SW-1:0]           r_slot_cnt;
  logic [DW-1:0]           r_digit_idx;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic                    r_pending;
  logic [NUM_DIGITS-1:0]   r_anodes;
  logic [6:0]              r_cathodes;

  logic                  w_slot_wrap;
  logic                  w_frame_wrap;
  logic                  w_xfer;
  logic                  w_live;
  logic                  w_show;
  logic                  w_digit_dark;
  logic [3:0]            w_nibble;
  logic [NUM_DIGITS-1:0] w_dark;
  logic [NUM_DIGITS-1:0] w_anodes_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign w_slot_wrap  = (r_slot_cnt == SLOT_LAST);
  assign w_frame_wrap = w_slot_wrap && (r_digit_idx == DIGIT_LAST);
  assign w_xfer       = load_valid && !r_pending;

  assign frame_tick = w_frame_wrap;
  assign load_ready = !r_pending;
  assign Anodes     = r_anodes;
  assign Cathodes   = r_cathodes;

  // Dead time at the start of each slot keeps the previous digit's segments
  // from ghosting onto the newly enabled anode.
  generate
    if (DEAD_CYCLES > 0) begin : g_dead
      assign w_live = (r_slot_cnt >= DEAD_LIM);
    end else begin : g_no_dead
      assign w_live = 1'b1;
    end
  endgenerate

`ifdef SEG7_LZ_BLANK_EN
  // A digit above 0 goes dark when it and every more-significant nibble are zero.
  always_comb begin : p_lz
    logic zero_above;
    zero_above = 1'b1;
    w_dark     = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (r_disp[4*i +: 4] == 4'h0);
      w_dark[i]  = zero_above;
    end
  end
`else
  assign w_dark = '0;
`endif

  always_comb begin : p_digit_sel
    w_nibble     = 4'h0;
    w_digit_dark = 1'b0;
    w_anodes_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit_idx == DW'(i)) begin
        w_nibble     = r_disp[4*i +: 4];
        w_digit_dark = w_dark[i];
      end
    end
    w_show = w_live && !blank && !w_digit_dark;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_show && (r_digit_idx == DW'(i))) begin
        w_anodes_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
      r_disp      <= '0;
      r_shadow    <= '0;
      r_pending   <= 1'b0;
      r_anodes    <= '1;
      r_cathodes  <= 7'b1111111;
    end else begin
      if (w_slot_wrap) begin
        r_slot_cnt  <= '0;
        r_digit_idx <= (r_digit_idx == DIGIT_LAST) ? '0 : r_digit_idx + DW'(1);
      end else begin
        r_slot_cnt  <= r_slot_cnt + SW'(1);
      end

      // Capture and commit are mutually exclusive: capture needs pending=0,
      // commit needs pending=1, so a capture on the frame edge waits a full frame.
      if (w_xfer) begin
        r_shadow  <= load_value;
        r_pending <= 1'b1;
      end else if (w_frame_wrap && r_pending) begin
        r_disp    <= r_shadow;
        r_pending <= 1'b0;
      end

      r_anodes   <= w_anodes_nxt;
      r_cathodes <= w_show ? hex7(w_nibble) : 7'b1111111;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int R  = 8;
  localparam int D  = 2;
  localparam int RN = N * R;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic        blank;
  logic        frame_tick;
  logic [3:0]  Anodes;
  logic [6:0]  Cathodes;

  always #5 clock = ~clock;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .blank      (blank),
    .frame_tick (frame_tick),
    .Anodes     (Anodes),
    .Cathodes   (Cathodes)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: cycle count since reset plus the display/shadow/pending registers.
  int          s;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  bit          m_pend;
  logic [6:0]  seg_tab [16];

  int         cnt_on    [4];
  logic [6:0] cath_seen [4];
  int         ft_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_out(input int st, input logic [15:0] d, input logic blk,
                                    output logic [3:0] an, output logic [6:0] ca);
    int slot;
    int idx;
    logic [15:0] up;
    bit dark;
    slot = st % R;
    idx  = (st / R) % N;
    an   = 4'b1111;
    ca   = 7'b1111111;
    up   = d >> (4 * idx);
    dark = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
    if (idx > 0 && up == 16'h0) dark = 1'b1;
`endif
    if (slot >= D && !blk && !dark) begin
      an[idx] = 1'b0;
      ca      = seg_tab[up[3:0]];
    end
  endfunction

  task automatic tick();
    logic [3:0]  ea;
    logic [6:0]  ec;
    bit          tr;
    bit          cm;
    logic [15:0] val;
    model_out(s, m_disp, blank, ea, ec);
    tr  = load_valid && !m_pend;
    cm  = ((s % RN) == RN - 1) && m_pend;
    val = load_value;
    @(posedge clock);
    s++;
    if (cm) begin
      m_disp = m_shadow;
      m_pend = 1'b0;
    end
    if (tr) begin
      m_shadow = val;
      m_pend   = 1'b1;
    end
    @(negedge clock);
    chk("anodes", 32'(Anodes), 32'(ea));
    chk("cathodes", 32'(Cathodes), 32'(ec));
    chk("frame_tick", 32'(frame_tick), 32'((s % RN) == RN - 1));
    chk("load_ready", 32'(load_ready), 32'(!m_pend));
    for (int i = 0; i < 4; i++) begin
      if (Anodes === ~(4'b0001 << i)) begin
        cnt_on[i]++;
        cath_seen[i] = Cathodes;
      end
    end
    if (frame_tick === 1'b1) ft_cnt++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < 4; i++) begin
      cnt_on[i]    = 0;
      cath_seen[i] = 7'b1111111;
    end
    ft_cnt = 0;
  endtask

  // Asserts reset away from a clock edge and checks outputs before any edge.
  task automatic do_reset();
    #2;
    reset_n    = 1'b0;
    load_valid = 1'b0;
    #1;
    chk("rst_anodes", 32'(Anodes), 32'h0000000F);
    chk("rst_cathodes", 32'(Cathodes), 32'h0000007F);
    chk("rst_load_ready", 32'(load_ready), 32'h1);
    chk("rst_frame_tick", 32'(frame_tick), 32'h0);
    @(negedge clock);
    reset_n  = 1'b1;
    s        = 0;
    m_disp   = '0;
    m_shadow = '0;
    m_pend   = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 3 * RN && m_pend; k++) tick();
    chk(tag, 32'(m_pend), 32'h0);
  endtask

  task automatic load(input logic [15:0] v);
    load_valid = 1'b1;
    load_value = v;
    wait_ready("load_wait");
    tick();
    load_valid = 1'b0;
  endtask

  task automatic wait_frame_start();
    for (int k = 0; k < RN && (s % RN) != 0; k++) tick();
  endtask

  task automatic show_frame();
    wait_ready("commit_wait");
    wait_frame_start();
    clear_cnt();
    run(RN);
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    load_valid = 1'b0;
    load_value = '0;
    blank      = 1'b0;
    reset_n    = 1'b1;
    clear_cnt();

    do_reset();
    run(3);

    // 12AF: digit0 'F', digit1 'A', digit3 '1', each lit 6 of 8 cycles.
    load(16'h12AF);
    show_frame();
    chk("t2_d0_on", 32'(cnt_on[0]), 32'd6);
    chk("t2_d0_seg", 32'(cath_seen[0]), 32'(7'b0001110));
    chk("t2_d1_seg", 32'(cath_seen[1]), 32'(7'b0001000));
    chk("t2_d3_on", 32'(cnt_on[3]), 32'd6);
    chk("t2_d3_seg", 32'(cath_seen[3]), 32'(7'b1111001));

    // Offer while not ready is ignored.
    load(16'h1111);
    load_valid = 1'b1;
    load_value = 16'h2222;
    run(10);
    load_valid = 1'b0;
    show_frame();
    for (int i = 0; i < 4; i++) chk("t3_seg", 32'(cath_seen[i]), 32'(7'b1111001));

    // Handshake on the frame_tick cycle commits only at the following frame_tick.
    for (int k = 0; k < RN && (s % RN) != RN - 1; k++) tick();
    chk("t4_tick_before", 32'(frame_tick), 32'h1);
    load_valid = 1'b1;
    load_value = 16'h5A5A;
    tick();
    load_valid = 1'b0;
    clear_cnt();
    run(RN);
    chk("t4_old_d0", 32'(cath_seen[0]), 32'(7'b1111001));
    chk("t4_ready_after", 32'(load_ready), 32'h1);
    clear_cnt();
    run(RN);
    chk("t4_new_d0", 32'(cath_seen[0]), 32'(7'b0001000));
    chk("t4_new_d1", 32'(cath_seen[1]), 32'(7'b0010010));

    // Blank for a full frame: nothing lit, frame_tick once per 32 cycles.
    blank = 1'b1;
    wait_frame_start();
    clear_cnt();
    run(RN);
    for (int i = 0; i < 4; i++) chk("t5_dark", 32'(cnt_on[i]), 32'd0);
    chk("t5_ticks", 32'(ft_cnt), 32'd1);
    blank = 1'b0;

    // 0030: leading-zero handling.
    load(16'h0030);
    show_frame();
    chk("t6_d0_on", 32'(cnt_on[0]), 32'd6);
    chk("t6_d0_seg", 32'(cath_seen[0]), 32'(7'b1000000));
    chk("t6_d1_seg", 32'(cath_seen[1]), 32'(7'b0110000));
`ifdef SEG7_LZ_BLANK_EN
    chk("t6_d2_on", 32'(cnt_on[2]), 32'd0);
    chk("t6_d3_on", 32'(cnt_on[3]), 32'd0);
`else
    chk("t6_d2_seg", 32'(cath_seen[2]), 32'(7'b1000000));
    chk("t6_d3_seg", 32'(cath_seen[3]), 32'(7'b1000000));
`endif

    // Reset while a value is pending discards it.
    load(16'hBEEF);
    run(5);
    do_reset();
    run(RN + 2);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blank = ~blank;
      tick();
    end
    load_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
